// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and constants for the I/D memory arbiter.
//                FSM state encoding, grant identifiers, bus width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Grant identifiers; also the encoding of the round-robin history bit.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the instruction-side, data-side and mem_system
//                signals handled by mem_arbiter.
//                slave  : arbiter view (requests in, completions out,
//                         mem_system commands out, mem_system status in)
//                master : environment view (pipeline stages + mem_system)
//  Ports       : none (signal bundle only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Instruction-fetch side
    logic              i_rd;
    logic [DATA_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_out;
    logic              i_done;
    logic              i_stall;
    logic              i_hit;
    logic              i_err;

    // Data side
    logic              d_rd;
    logic              d_wr;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic [DATA_W-1:0] d_data_out;
    logic              d_done;
    logic              d_stall;
    logic              d_hit;
    logic              d_err;

    // mem_system side
    logic [DATA_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_in;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_data_out;
    logic              m_done;
    logic              m_stall;
    logic              m_hit;
    logic              m_err;

    modport slave (
        input  i_rd, i_addr,
        output i_data_out, i_done, i_stall, i_hit, i_err,
        input  d_rd, d_wr, d_addr, d_data_in,
        output d_data_out, d_done, d_stall, d_hit, d_err,
        output m_addr, m_data_in, m_rd, m_wr,
        input  m_data_out, m_done, m_stall, m_hit, m_err
    );

    modport master (
        output i_rd, i_addr,
        input  i_data_out, i_done, i_stall, i_hit, i_err,
        output d_rd, d_wr, d_addr, d_data_in,
        input  d_data_out, d_done, d_stall, d_hit, d_err,
        input  m_addr, m_data_in, m_rd, m_wr,
        output m_data_out, m_done, m_stall, m_hit, m_err
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin picker. A lone requester always wins;
//                on a tie the side that was NOT granted last time wins.
//  Ports       : i_req_i      in  1  instruction side requesting
//                i_req_d      in  1  data side requesting
//                i_last_grant in  1  side granted previously (GRANT_I/D)
//                o_grant      out 1  chosen side (GRANT_I/D)
//                o_valid      out 1  at least one side requesting
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  wire logic i_req_i,
    input  wire logic i_req_d,
    input  wire logic i_last_grant,
    output logic      o_grant,
    output logic      o_valid
);

    always_comb begin
        o_valid = i_req_i | i_req_d;
        o_grant = GRANT_I;
        if (i_req_i && i_req_d) begin
            o_grant = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (i_req_d) begin
            o_grant = GRANT_D;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one mem_system between the instruction-fetch (I) and
//                data (D) requesters. Round-robin arbitration, one Rd/Wr
//                command per transaction, waits for Done (with timeout) and
//                returns data/hit/err to the granted side for one cycle.
//  Parameters  : TIMEOUT  WAIT cycles before a forced error completion
//                CNT_W    timeout counter width (must hold TIMEOUT)
//  Ports       : clk      in  1  clock
//                rst      in  1  asynchronous reset, active-high
//                bus      mem_arbiter_if.slave
//                         I side  : i_rd/i_addr -> i_data_out/done/stall/hit/err
//                         D side  : d_rd/d_wr/d_addr/d_data_in -> d_* results
//                         mem     : m_addr/m_data_in/m_rd/m_wr out,
//                                   m_data_out/m_done/m_stall/m_hit/m_err in
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant;
    logic               r_last;
    logic               r_is_wr;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_hit;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_req_d;
    logic               w_pick;
    logic               w_valid;
    logic               w_conflict;
    logic               w_tmo;
    logic               w_done_i;
    logic               w_done_d;

    assign w_req_d = bus.d_rd | bus.d_wr;

    rr_arb2 u_rr_arb2 (
        .i_req_i      (bus.i_rd),
        .i_req_d      (w_req_d),
        .i_last_grant (r_last),
        .o_grant      (w_pick),
        .o_valid      (w_valid)
    );

    // A data request asking for both read and write is malformed: it is
    // never sent to mem_system and completes straight away with an error.
    assign w_conflict = (w_pick == GRANT_D) & bus.d_rd & bus.d_wr;

    // Fires on the last of TIMEOUT consecutive WAIT cycles.
    assign w_tmo = (r_state == ST_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_done_i       = 1'b0;
        w_done_d       = 1'b0;
        bus.m_rd       = 1'b0;
        bus.m_wr       = 1'b0;
        bus.m_addr     = r_addr;
        bus.m_data_in  = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = w_conflict ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.m_rd = ~r_is_wr;
                bus.m_wr =  r_is_wr;
                // mem_system ignores commands while stalled: keep presenting.
                if (!bus.m_stall) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_done || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_done_i    = (r_grant == GRANT_I);
                w_done_d    = (r_grant == GRANT_D);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        bus.i_done     = w_done_i;
        bus.i_data_out = w_done_i ? r_rdata : '0;
        bus.i_hit      = w_done_i & r_hit;
        bus.i_err      = w_done_i & r_err;
        bus.i_stall    = bus.i_rd & ~w_done_i;

        bus.d_done     = w_done_d;
        bus.d_data_out = w_done_d ? r_rdata : '0;
        bus.d_hit      = w_done_d & r_hit;
        bus.d_err      = w_done_d & r_err;
        bus.d_stall    = w_req_d & ~w_done_d;
    end

    // ------------------------------------------------------------------
    // Transaction latches and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= GRANT_I;
            r_last  <= GRANT_D;     // I wins the first tie after reset
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_pick;
                        r_addr  <= (w_pick == GRANT_I) ? bus.i_addr : bus.d_addr;
                        r_wdata <= (w_pick == GRANT_I) ? '0 : bus.d_data_in;
                        r_is_wr <= (w_pick == GRANT_D) & bus.d_wr & ~bus.d_rd;
                        r_rdata <= '0;
                        r_hit   <= 1'b0;
                        r_err   <= w_conflict;
                    end
                end
                ST_WAIT: begin
                    if (bus.m_done) begin
                        r_rdata <= r_is_wr ? '0 : bus.m_data_out;
                        r_hit   <= bus.m_hit;
                        r_err   <= bus.m_err;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_hit   <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last <= r_grant;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // WAIT-cycle counter, cleared whenever the FSM is elsewhere
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule : mem_arbiter
`default_nettype wire
